axis_frame_ram_writer: RTL and testbench
========================================

// Module: axis_frame_ram_writer
// PURPOSE
//  Ingress stage in front of the byte-write frame RAM. Accepts an 8-bit AXI-Stream Ethernet frame
//  stream and packs the bytes into RAM words with per-byte write enables. Frames are laid out in a
//  circular buffer of word addresses; each frame starts on a word boundary.
//  A frame is committed on a good tlast. It is rolled back on tuser=1 (bad frame) or on buffer overflow.
// PARAMETERS
//  NUM_COL     4   byte lanes per RAM word
//  COL_WIDTH   8   bits per lane; fixed at 8
//  ADDR_WIDTH  9   RAM word address width; depth = 2**ADDR_WIDTH words
//  LEN_WIDTH   16  frame length counter width, in bytes
// PORTS
//  clk              in   1                       single clock for all logic
//  rst              in   1                       synchronous, active-high reset
//  s_axis_tdata     in   8                       frame byte
//  s_axis_tvalid    in   1                       byte valid
//  s_axis_tready    out  1                       byte accept
//  s_axis_tlast     in   1                       last byte of frame
//  s_axis_tuser     in   1                       bad-frame flag; sampled with tlast only
//  rd_ptr           in   ADDR_WIDTH+1            consumer's free-word pointer (word units, extra wrap bit)
//  ram_en           out  1                       RAM port enable
//  ram_we           out  NUM_COL                 RAM byte-write enables
//  ram_addr         out  ADDR_WIDTH              RAM word address
//  ram_din          out  NUM_COL*COL_WIDTH       RAM write data
//  commit_ptr       out  ADDR_WIDTH+1            end of last committed frame (exclusive)
//  frame_valid      out  1                       1-cycle pulse: frame committed
//  frame_len        out  LEN_WIDTH               byte length of committed frame; valid with frame_valid
//  drop_bad         out  1                       1-cycle pulse: frame dropped due to tuser
//  drop_overflow    out  1                       1-cycle pulse: frame dropped due to full buffer
// BEHAVIOUR
//  - Reset: every output is 0, including s_axis_tready. All pointers, the lane counter and the length
//    counter are 0, and the FSM is in IDLE. s_axis_tready rises the cycle after rst deasserts.
//  - Internal state: wr_ptr (ADDR_WIDTH+1), lane (0..NUM_COL-1), len (LEN_WIDTH).
//    All pointer arithmetic is mod 2**(ADDR_WIDTH+1). ram_addr = wr_ptr[ADDR_WIDTH-1:0].
//  - FSM states:
//      IDLE:  first accepted byte moves to WRITE, or to DROP on overflow.
//      WRITE: tlast moves to IDLE. Overflow moves to DROP.
//      DROP:  discards bytes; tlast moves to IDLE.
//  - After reset, s_axis_tready is held at 1 in all states. The block never stalls; overflow drops the frame.
//  - Overflow: a byte accepted at lane 0 while (wr_ptr - rd_ptr) == 2**ADDR_WIDTH. That byte is not written.
//  - Write latency is 1 cycle. For a byte accepted in WRITE/IDLE without overflow, the next cycle has:
//      ram_en = 1
//      ram_we = 1 << lane
//      ram_din = tdata replicated on all lanes
//      ram_addr = current word address
//    ram_en and ram_we are 0 in every other cycle.
//  - Lane advance: lane increments per written byte. On lane == NUM_COL-1, wr_ptr increments and lane wraps to 0.
//  - len increments per accepted byte and saturates at all-ones. It clears on frame end.
//  - Good tlast (tuser=0, no overflow), in the cycle after acceptance:
//      frame_valid = 1, frame_len = len including the last byte.
//      commit_ptr = word after the last written word (partial word rounded up).
//      wr_ptr = commit_ptr; lane = 0.
//  - Bad tlast (tuser=1) in WRITE/IDLE: the last byte is still written. The next cycle has drop_bad = 1,
//    wr_ptr = commit_ptr, lane = 0, and commit_ptr unchanged.
//  - Entering DROP: drop_overflow pulses once, the cycle after the overflowing byte. wr_ptr is restored to
//    commit_ptr. Further bytes are ignored; tlast/tuser in DROP produce no extra pulse.
//  - Overflow on a tlast byte: counts as overflow. drop_overflow pulses only; no frame_valid, no drop_bad.
//  - Single-byte frame (tvalid & tlast in IDLE): written and committed as 1 byte; commit_ptr advances 1 word.
//  - rd_ptr is trusted to lie between (commit_ptr - 2**ADDR_WIDTH) and commit_ptr. It is sampled each cycle.
//  - Reset mid-frame: partial frame lost, no pulse emitted; the consumer must reset rd_ptr together.
// TESTING
//  1. Reset, then a 6-byte frame 11..16, tuser=0 ->
//       writes addr0 we 0001,0010,0100,1000; then addr1 we 0001,0010.
//       frame_valid=1, frame_len=6, commit_ptr=2.
//  2. Frame 1 as in test 1, then a 5-byte frame with tuser=1 on tlast -> drop_bad=1, commit_ptr stays 2.
//     The next 4-byte frame writes addr2 and commits commit_ptr=3.
//  3. ADDR_WIDTH=2, rd_ptr=0, a 20-byte frame -> bytes 1..16 are written to addr0..3.
//     Byte 17 overflows: drop_overflow=1, no further writes, tready stays 1, commit_ptr=0.
//  4. ADDR_WIDTH=2, commit_ptr=rd_ptr=6, a 12-byte frame -> writes addr 2,3,0. frame_valid=1, commit_ptr=1 (mod 8).
//  5. Back-to-back 1-byte frames, tvalid held high for 3 cycles -> three frame_valid pulses with frame_len=1,
//     writes addr 0,1,2 with we=0001 each, commit_ptr=3.
//  6. rst asserted for 1 cycle after byte 3 of a frame -> all outputs 0 the cycle after rst. tready rises the next cycle.
//     A new 2-byte frame writes addr0 and commits commit_ptr=1.

Source files
------------

// File: rtl/axis_frame_ram_writer_if.sv
// Byte-wide AXI-Stream ingress bundle for the frame RAM writer.
// The producer drives data/valid/last/user and the writer returns tready.
interface axis_frame_ram_writer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_frame_ram_writer.sv
// Packs an 8-bit AXI-Stream frame into byte-enabled RAM words in a circular buffer,
// committing good frames and rolling back bad or overflowing ones.
module axis_frame_ram_writer #(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    axis_frame_ram_writer_if.slave        s_axis,
    input  logic [ADDR_WIDTH:0]           rd_ptr,
    output logic                          ram_en,
    output logic [NUM_COL-1:0]            ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [NUM_COL*COL_WIDTH-1:0]  ram_din,
    output logic [ADDR_WIDTH:0]           commit_ptr,
    output logic                          frame_valid,
    output logic [LEN_WIDTH-1:0]          frame_len,
    output logic                          drop_bad,
    output logic                          drop_overflow
);
    localparam int LANE_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam logic [ADDR_WIDTH:0] FULL_FILL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [LANE_W-1:0]   LAST_LANE = LANE_W'(NUM_COL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t                         state_q;
    logic                           tready_q;
    logic [ADDR_WIDTH:0]            wr_ptr_q;
    logic [ADDR_WIDTH:0]            commit_ptr_q;
    logic [LANE_W-1:0]              lane_q;
    logic [LEN_WIDTH-1:0]           len_q;
    logic                           ram_en_q;
    logic [NUM_COL-1:0]             ram_we_q;
    logic [ADDR_WIDTH-1:0]          ram_addr_q;
    logic [NUM_COL*COL_WIDTH-1:0]   ram_din_q;
    logic                           frame_valid_q;
    logic [LEN_WIDTH-1:0]           frame_len_q;
    logic                           drop_bad_q;
    logic                           drop_overflow_q;

    logic                           accept_d;
    logic                           overflow_d;
    logic                           write_d;
    logic [ADDR_WIDTH:0]            fill_d;
    logic [ADDR_WIDTH:0]            wr_ptr_inc_d;
    logic [LEN_WIDTH-1:0]           len_d;

    // Overflow is only judged when a byte would open a fresh word.
    always_comb begin
        accept_d     = s_axis.tvalid & tready_q;
        fill_d       = wr_ptr_q - rd_ptr;
        wr_ptr_inc_d = wr_ptr_q + 1'b1;
        len_d        = (&len_q) ? len_q : len_q + 1'b1;
        overflow_d   = accept_d && (state_q != DROP) && (lane_q == '0) && (fill_d == FULL_FILL);
        write_d      = accept_d && (state_q != DROP) && !overflow_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            tready_q        <= 1'b0;
            wr_ptr_q        <= '0;
            commit_ptr_q    <= '0;
            lane_q          <= '0;
            len_q           <= '0;
            ram_en_q        <= 1'b0;
            ram_we_q        <= '0;
            ram_addr_q      <= '0;
            ram_din_q       <= '0;
            frame_valid_q   <= 1'b0;
            frame_len_q     <= '0;
            drop_bad_q      <= 1'b0;
            drop_overflow_q <= 1'b0;
        end else begin
            tready_q        <= 1'b1;
            ram_en_q        <= write_d;
            ram_we_q        <= write_d ? (NUM_COL'(1) << lane_q) : '0;
            frame_valid_q   <= 1'b0;
            drop_bad_q      <= 1'b0;
            drop_overflow_q <= 1'b0;

            if (write_d) begin
                ram_addr_q <= wr_ptr_q[ADDR_WIDTH-1:0];
                ram_din_q  <= {NUM_COL{s_axis.tdata}};
            end

            if (accept_d) begin
                len_q <= len_d;
            end

            case (state_q)
                IDLE, WRITE: begin
                    if (accept_d) begin
                        if (overflow_d) begin
                            drop_overflow_q <= 1'b1;
                            wr_ptr_q        <= commit_ptr_q;
                            lane_q          <= '0;
                            if (s_axis.tlast) begin
                                state_q <= IDLE;
                                len_q   <= '0;
                            end else begin
                                state_q <= DROP;
                            end
                        end else if (s_axis.tlast) begin
                            // The last word is closed even when partially filled.
                            state_q <= IDLE;
                            lane_q  <= '0;
                            len_q   <= '0;
                            if (s_axis.tuser) begin
                                drop_bad_q <= 1'b1;
                                wr_ptr_q   <= commit_ptr_q;
                            end else begin
                                frame_valid_q <= 1'b1;
                                frame_len_q   <= len_d;
                                commit_ptr_q  <= wr_ptr_inc_d;
                                wr_ptr_q      <= wr_ptr_inc_d;
                            end
                        end else begin
                            state_q <= WRITE;
                            if (lane_q == LAST_LANE) begin
                                lane_q   <= '0;
                                wr_ptr_q <= wr_ptr_inc_d;
                            end else begin
                                lane_q <= lane_q + 1'b1;
                            end
                        end
                    end
                end
                DROP: begin
                    if (accept_d && s_axis.tlast) begin
                        state_q <= IDLE;
                        len_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_axis.tready = tready_q;
    assign ram_en        = ram_en_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_din       = ram_din_q;
    assign commit_ptr    = commit_ptr_q;
    assign frame_valid   = frame_valid_q;
    assign frame_len     = frame_len_q;
    assign drop_bad      = drop_bad_q;
    assign drop_overflow = drop_overflow_q;
endmodule

// File: tb/tb_axis_frame_ram_writer.sv
// Table-driven bench for axis_frame_ram_writer on a 4-word buffer (ADDR_WIDTH=2);
// each applied cycle queues the outputs expected after the next clock edge.
module tb_axis_frame_ram_writer;
    localparam int AW = 2;

    typedef struct {
        bit          rst;
        bit          v;
        bit          l;
        bit          u;
        logic [7:0]  d;
        logic [AW:0] rd;
        bit          en;
        logic [3:0]  we;
        logic [1:0]  addr;
        bit          fv;
        logic [15:0] flen;
        logic [AW:0] cp;
        bit          db;
        bit          dov;
        bit          rdy;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [AW:0]   rd_ptr;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [AW:0]   commit_ptr;
    logic          frame_valid;
    logic [15:0]   frame_len;
    logic          drop_bad;
    logic          drop_overflow;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];
    vec_t sb[$];

    axis_frame_ram_writer_if #(.DATA_W(8)) s_if ();

    axis_frame_ram_writer #(
        .NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(AW), .LEN_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .s_axis(s_if), .rd_ptr(rd_ptr),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .commit_ptr(commit_ptr), .frame_valid(frame_valid), .frame_len(frame_len),
        .drop_bad(drop_bad), .drop_overflow(drop_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic vec_t rstv();
        vec_t x = '{default: '0};
        x.rst = 1'b1;
        return x;
    endfunction

    function automatic vec_t nop(input logic [AW:0] rd, input logic [AW:0] cp);
        vec_t x = '{default: '0};
        x.rd  = rd;
        x.cp  = cp;
        x.rdy = 1'b1;
        return x;
    endfunction

    function automatic vec_t byt(input logic [7:0] d, input bit l, input bit u, input logic [AW:0] rd,
                                 input logic [3:0] we, input logic [1:0] addr, input bit fv,
                                 input logic [15:0] flen, input logic [AW:0] cp, input bit db, input bit dov);
        vec_t x = '{default: '0};
        x.v = 1'b1; x.l = l; x.u = u; x.d = d; x.rd = rd;
        x.en = (we != 4'd0); x.we = we; x.addr = addr;
        x.fv = fv; x.flen = flen; x.cp = cp; x.db = db; x.dov = dov; x.rdy = 1'b1;
        return x;
    endfunction

    task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %0h expected %0h", idx, nm, act, exp);
        end
    endtask

    int step_no = 0;

    task automatic apply(input vec_t x);
        vec_t e;
        rst         = x.rst;
        s_if.tvalid = x.v;
        s_if.tlast  = x.l;
        s_if.tuser  = x.u;
        s_if.tdata  = x.d;
        rd_ptr      = x.rd;
        sb.push_back(x);
        @(negedge clk);
        e = sb.pop_front();
        chk(step_no, "tready", 32'(s_if.tready), 32'(e.rdy));
        chk(step_no, "ram_en", 32'(ram_en), 32'(e.en));
        chk(step_no, "ram_we", 32'(ram_we), 32'(e.we));
        if (e.en) begin
            chk(step_no, "ram_addr", 32'(ram_addr), 32'(e.addr));
            chk(step_no, "ram_din", ram_din, {4{e.d}});
        end
        chk(step_no, "frame_valid", 32'(frame_valid), 32'(e.fv));
        if (e.fv) chk(step_no, "frame_len", 32'(frame_len), 32'(e.flen));
        chk(step_no, "commit_ptr", 32'(commit_ptr), 32'(e.cp));
        chk(step_no, "drop_bad", 32'(drop_bad), 32'(e.db));
        chk(step_no, "drop_overflow", 32'(drop_overflow), 32'(e.dov));
        step_no++;
    endtask

    initial begin
        rst = 1'b1; rd_ptr = '0;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = 1'b0; s_if.tdata = '0;

        // 6-byte good frame with a valid gap and a stray tuser on a middle byte.
        tbl.push_back(rstv());
        tbl.push_back(nop(0, 0));
        tbl.push_back(byt(8'd11, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
        tbl.push_back(byt(8'd12, 0, 1, 0, 4'b0010, 0, 0, 0, 0, 0, 0));
        tbl.push_back(byt(8'd13, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0, 0));
        tbl.push_back(byt(8'd14, 0, 0, 0, 4'b1000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(byt(8'd15, 0, 0, 0, 4'b0001, 1, 0, 0, 0, 0, 0));
        tbl.push_back(byt(8'd16, 1, 0, 0, 4'b0010, 1, 1, 6, 2, 0, 0));
        // Bad 5-byte frame, then a 4-byte frame reusing the rolled-back word.
        tbl.push_back(byt(8'd21, 0, 0, 0, 4'b0001, 2, 0, 0, 2, 0, 0));
        tbl.push_back(byt(8'd22, 0, 0, 0, 4'b0010, 2, 0, 0, 2, 0, 0));
        tbl.push_back(byt(8'd23, 0, 0, 0, 4'b0100, 2, 0, 0, 2, 0, 0));
        tbl.push_back(byt(8'd24, 0, 0, 0, 4'b1000, 2, 0, 0, 2, 0, 0));
        tbl.push_back(byt(8'd25, 1, 1, 0, 4'b0001, 3, 0, 0, 2, 1, 0));
        tbl.push_back(byt(8'd31, 0, 0, 0, 4'b0001, 2, 0, 0, 2, 0, 0));
        tbl.push_back(byt(8'd32, 0, 0, 0, 4'b0010, 2, 0, 0, 2, 0, 0));
        tbl.push_back(byt(8'd33, 0, 0, 0, 4'b0100, 2, 0, 0, 2, 0, 0));
        tbl.push_back(byt(8'd34, 1, 0, 0, 4'b1000, 2, 1, 4, 3, 0, 0));
        tbl.push_back(nop(0, 3));
        // Back-to-back single-byte frames.
        tbl.push_back(rstv());
        tbl.push_back(nop(0, 0));
        tbl.push_back(byt(8'hA1, 1, 0, 0, 4'b0001, 0, 1, 1, 1, 0, 0));
        tbl.push_back(byt(8'hA2, 1, 0, 0, 4'b0001, 1, 1, 1, 2, 0, 0));
        tbl.push_back(byt(8'hA3, 1, 0, 0, 4'b0001, 2, 1, 1, 3, 0, 0));
        tbl.push_back(nop(0, 3));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // 20-byte frame into an empty 4-word buffer: byte 17 overflows.
        apply(rstv());
        apply(nop(0, 0));
        for (int i = 1; i <= 20; i++) begin
            if (i <= 16)
                apply(byt(8'(i), 0, 0, 0, 4'(1 << ((i - 1) % 4)), 2'((i - 1) / 4), 0, 0, 0, 0, 0));
            else if (i == 17)
                apply(byt(8'(i), 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1));
            else
                apply(byt(8'(i), i == 20, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
        end
        apply(nop(0, 0));

        // Wrap-around: fill to commit 4, then a 5-byte frame rounds up to 6, then wrap to 1.
        apply(rstv());
        apply(nop(0, 0));
        for (int i = 0; i < 16; i++)
            apply(byt(8'(40 + i), i == 15, 0, 0, 4'(1 << (i % 4)), 2'(i / 4), i == 15, 16,
                      (i == 15) ? 3'd4 : 3'd0, 0, 0));
        for (int i = 0; i < 5; i++)
            apply(byt(8'(60 + i), i == 4, 0, 4, 4'(1 << (i % 4)), 2'(i / 4), i == 4, 5,
                      (i == 4) ? 3'd6 : 3'd4, 0, 0));
        for (int i = 0; i < 12; i++)
            apply(byt(8'(70 + i), i == 11, 0, 6, 4'(1 << (i % 4)), 2'((2 + i / 4) % 4), i == 11, 12,
                      (i == 11) ? 3'd1 : 3'd6, 0, 0));
        // Buffer full across the pointer wrap; the overflowing byte carries tlast and tuser.
        for (int i = 0; i < 5; i++) begin
            if (i < 4)
                apply(byt(8'(90 + i), 0, 0, 6, 4'(1 << i), 2'd1, 0, 0, 1, 0, 0));
            else
                apply(byt(8'(90 + i), 1, 1, 6, 4'b0000, 0, 0, 0, 1, 0, 1));
        end
        apply(nop(6, 1));

        // Reset in the middle of a frame, then a fresh 2-byte frame.
        apply(rstv());
        apply(nop(0, 0));
        apply(byt(8'hC1, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
        apply(byt(8'hC2, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0));
        apply(byt(8'hC3, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 0));
        apply(rstv());
        apply(nop(0, 0));
        apply(byt(8'hD1, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
        apply(byt(8'hD2, 1, 0, 0, 4'b0010, 0, 1, 2, 1, 0, 0));
        apply(nop(0, 1));

        chk(step_no, "scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
